serial_programmer: RTL and testbench

SERIAL_PROGRAMMER -- requirements
Module: serial_programmer

---
 rtl/serial_programmer_pkg.sv | 17 +
 rtl/sync2.sv | 24 ++
 rtl/serial_programmer.sv | 149 ++++++++++++++
 tb/tb_serial_programmer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_programmer_pkg.sv
// Shared types and frame constants for the serial gain-stage programmer.
package serial_programmer_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRst,
        StShift,
        StWait,
        StDone,
        StError
    } state_e;

    localparam int unsigned FrameLen = 6;
    localparam int unsigned GainA1W  = 2;
    localparam int unsigned GainA2W  = 3;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level input.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic ff1_q;
    logic ff2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff1_q <= 1'b0;
            ff2_q <= 1'b0;
        end else begin
            ff1_q <= d;
            ff2_q <= ff1_q;
        end
    end

    assign q = ff2_q;

endmodule

// File: rtl/serial_programmer.sv
// Resets a downstream gain stage, shifts a 6-bit gain frame out serially, then waits for ready.
module serial_programmer
    import serial_programmer_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned RST_CYCLES = 4,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [GainA1W-1:0] i_gainA1,
    input  logic [GainA2W-1:0] i_gainA2,
    input  logic               i_ready,
    output logic               o_resetbAll,
    output logic               o_sclk,
    output logic               o_sdin,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err
);

    localparam logic [9:0] RstLast = 10'(RST_CYCLES - 1);
    localparam logic [9:0] DivLast = 10'(CLK_DIV - 1);
    localparam logic [9:0] ToLast  = 10'(TIMEOUT - 1);
    localparam logic [2:0] BitLast = 3'(FrameLen - 1);

    state_e               state_q, state_d;
    logic [9:0]           cnt_q, cnt_d;
    logic [2:0]           bit_q, bit_d;
    logic [2:0]           bit_nxt;
    logic                 sclk_q, sclk_d;
    logic                 sdin_q, sdin_d;
    logic                 resetb_q, resetb_d;
    logic [GainA1W-1:0]   a1_q, a1_d;
    logic [GainA2W-1:0]   a2_q, a2_d;
    logic [FrameLen-1:0]  frame;
    logic                 ready_sync;

    sync2 u_sync_ready (
        .clk (i_clk),
        .rst (i_reset),
        .d   (i_ready),
        .q   (ready_sync)
    );

    // Bit 0 is the dummy lead bit, then A1 LSB-first, then A2 LSB-first.
    assign frame   = {a2_q, a1_q, 1'b0};
    assign bit_nxt = bit_q + 3'd1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        sclk_d   = sclk_q;
        sdin_d   = sdin_q;
        resetb_d = resetb_q;
        a1_d     = a1_q;
        a2_d     = a2_q;
        unique case (state_q)
            StIdle, StDone, StError: begin
                if (state_q == StDone) state_d = StIdle;
                if (i_start) begin
                    state_d  = StRst;
                    a1_d     = i_gainA1;
                    a2_d     = i_gainA2;
                    cnt_d    = '0;
                    bit_d    = '0;
                    sclk_d   = 1'b0;
                    sdin_d   = 1'b0;
                    resetb_d = 1'b0;
                end
            end
            StRst: begin
                if (cnt_q == RstLast) begin
                    state_d  = StShift;
                    cnt_d    = '0;
                    bit_d    = '0;
                    resetb_d = 1'b1;
                    sdin_d   = frame[0];
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            StShift: begin
                if (cnt_q == DivLast) begin
                    cnt_d  = '0;
                    sclk_d = ~sclk_q;
                    // Data only moves on the falling edge of sclk.
                    if (sclk_q) begin
                        if (bit_q == BitLast) begin
                            state_d = StWait;
                            sclk_d  = 1'b0;
                            sdin_d  = 1'b0;
                            bit_d   = '0;
                        end else begin
                            bit_d  = bit_nxt;
                            sdin_d = frame[bit_nxt];
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            StWait: begin
                if (ready_sync) begin
                    state_d = StDone;
                    cnt_d   = '0;
                end else if (cnt_q == ToLast) begin
                    state_d = StError;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            bit_q    <= '0;
            sclk_q   <= 1'b0;
            sdin_q   <= 1'b0;
            resetb_q <= 1'b0;
            a1_q     <= '0;
            a2_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            sclk_q   <= sclk_d;
            sdin_q   <= sdin_d;
            resetb_q <= resetb_d;
            a1_q     <= a1_d;
            a2_q     <= a2_d;
        end
    end

    assign o_resetbAll = resetb_q;
    assign o_sclk      = sclk_q;
    assign o_sdin      = sdin_q;
    assign o_busy      = (state_q == StRst) || (state_q == StShift) || (state_q == StWait);
    assign o_done      = (state_q == StDone);
    assign o_err       = (state_q == StError);

endmodule

// File: tb/tb_serial_programmer.sv
// Bench for serial_programmer: table-driven frames with an sdin scoreboard, plus reset and CLK_DIV=1 cases.
module tb_serial_programmer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] gain_a1 = '0;
    logic [2:0] gain_a2 = '0;
    logic       ready = 1'b0;
    logic       resetb, sclk, sdin, busy, done, err;

    logic       start1 = 1'b0;
    logic [1:0] gain1_a1 = '0;
    logic [2:0] gain1_a2 = '0;
    logic       ready1 = 1'b1;
    logic       resetb1, sclk1, sdin1, busy1, done1, err1;

    int checks = 0;
    int errors = 0;
    int rises  = 0;
    logic sclk_prev = 1'b0;
    logic exp_q[$];

    always #5 clk = ~clk;

    serial_programmer dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_start     (start),
        .i_gainA1    (gain_a1),
        .i_gainA2    (gain_a2),
        .i_ready     (ready),
        .o_resetbAll (resetb),
        .o_sclk      (sclk),
        .o_sdin      (sdin),
        .o_busy      (busy),
        .o_done      (done),
        .o_err       (err)
    );

    serial_programmer #(.CLK_DIV(1)) dut1 (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_start     (start1),
        .i_gainA1    (gain1_a1),
        .i_gainA2    (gain1_a2),
        .i_ready     (ready1),
        .o_resetbAll (resetb1),
        .o_sclk      (sclk1),
        .o_sdin      (sdin1),
        .o_busy      (busy1),
        .o_done      (done1),
        .o_err       (err1)
    );

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every sclk rise pops the next expected sdin bit.
    always @(negedge clk) begin
        if (sclk && !sclk_prev) begin
            rises++;
            if (exp_q.size() == 0) begin
                check("sdin_unexpected_rise", 1, 0);
            end else begin
                check("sdin_bit", int'(sdin), int'(exp_q.pop_front()));
            end
        end
        sclk_prev = sclk;
    end

    typedef struct {
        logic [1:0] a1;
        logic [2:0] a2;
        int         rdy;
        int         done_at;
        int         err_at;
        int         glitch;
    } vec_t;

    task automatic push_frame(input logic [1:0] a1, input logic [2:0] a2);
        exp_q.push_back(1'b0);
        exp_q.push_back(a1[0]);
        exp_q.push_back(a1[1]);
        exp_q.push_back(a2[0]);
        exp_q.push_back(a2[1]);
        exp_q.push_back(a2[2]);
    endtask

    task automatic run_frame(input vec_t v);
        int low;
        int busy_bad;
        int fin;
        start = 1'b1;
        gain_a1 = v.a1;
        gain_a2 = v.a2;
        tick();
        start = 1'b0;
        push_frame(v.a1, v.a2);
        rises = 0;
        check("busy_on_accept", int'(busy), 1);
        check("err_cleared_on_accept", int'(err), 0);
        check("resetb_low_on_accept", int'(resetb), 0);
        low = 1;
        while (resetb === 1'b0 && low < 50) begin
            tick();
            if (resetb === 1'b0) low++;
        end
        check("resetb_low_cycles", low, 4);
        check("sclk_low_at_shift_entry", int'(sclk), 0);
        busy_bad = 0;
        for (int j = 1; j <= 24; j++) begin
            if (j == v.glitch) begin
                start = 1'b1;
                gain_a1 = 2'b11;
                gain_a2 = 3'b111;
            end
            tick();
            start = 1'b0;
            if (busy !== 1'b1 || done !== 1'b0) busy_bad++;
        end
        check("busy_through_shift", busy_bad, 0);
        check("sclk_low_at_wait", int'(sclk), 0);
        check("sdin_low_at_wait", int'(sdin), 0);
        check("rise_count", rises, 6);
        check("bits_consumed", exp_q.size(), 0);
        fin = (v.done_at != 0) ? v.done_at : v.err_at;
        if (v.rdy == 0) ready = 1'b1;
        for (int t = 1; t <= 70; t++) begin
            tick();
            check("done_timing", int'(done), (t == v.done_at) ? 1 : 0);
            check("err_timing", int'(err), (v.err_at != 0 && t >= v.err_at) ? 1 : 0);
            check("busy_in_wait", int'(busy), (t < fin) ? 1 : 0);
            check("resetb_high_after_frame", int'(resetb), 1);
            if (t == v.rdy) ready = 1'b1;
        end
        ready = 1'b0;
        repeat (4) tick();
    endtask

    vec_t vecs[6];
    logic [5:0] bits1;
    int seen_done;
    int bad_idle;

    initial begin
        vecs[0] = '{a1: 2'b10, a2: 3'b101, rdy: 10, done_at: 13, err_at: 0,  glitch: 0};
        vecs[1] = '{a1: 2'b01, a2: 3'b010, rdy: -1, done_at: 0,  err_at: 64, glitch: 0};
        vecs[2] = '{a1: 2'b11, a2: 3'b111, rdy: 61, done_at: 64, err_at: 0,  glitch: 0};
        vecs[3] = '{a1: 2'b00, a2: 3'b000, rdy: 62, done_at: 0,  err_at: 64, glitch: 0};
        vecs[4] = '{a1: 2'b01, a2: 3'b110, rdy: 0,  done_at: 3,  err_at: 0,  glitch: 0};
        vecs[5] = '{a1: 2'b00, a2: 3'b001, rdy: 5,  done_at: 8,  err_at: 0,  glitch: 7};

        #12;
        check("rst_resetb", int'(resetb), 0);
        check("rst_sclk", int'(sclk), 0);
        check("rst_sdin", int'(sdin), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) tick();
        check("idle_resetb_low", int'(resetb), 0);
        check("idle_busy", int'(busy), 0);

        for (int i = 0; i < 6; i++) run_frame(vecs[i]);

        // Reset asserted while sclk is high on the 3rd rise aborts the frame.
        start = 1'b1;
        gain_a1 = 2'b10;
        gain_a2 = 3'b101;
        tick();
        start = 1'b0;
        push_frame(2'b10, 3'b101);
        rises = 0;
        for (int i = 0; i < 100 && rises < 3; i++) tick();
        check("third_rise_reached", rises, 3);
        check("sclk_high_at_third_rise", int'(sclk), 1);
        rst = 1'b1;
        #1;
        check("abort_resetb", int'(resetb), 0);
        check("abort_sclk", int'(sclk), 0);
        check("abort_sdin", int'(sdin), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_err", int'(err), 0);
        exp_q.delete();
        repeat (2) tick();
        rst = 1'b0;
        seen_done = 0;
        bad_idle = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) seen_done++;
            if (resetb !== 1'b0 || busy !== 1'b0) bad_idle++;
        end
        check("no_done_after_abort", seen_done, 0);
        check("idle_after_abort", bad_idle, 0);
        run_frame(vecs[0]);

        // CLK_DIV=1 instance with ready held high from the start.
        bits1 = 6'b011010;
        start1 = 1'b1;
        gain1_a1 = 2'b01;
        gain1_a2 = 3'b011;
        tick();
        start1 = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            tick();
            check("div1_resetb_low", int'(resetb1), 0);
            check("div1_no_early_done", int'(done1), 0);
        end
        tick();
        check("div1_resetb_release", int'(resetb1), 1);
        for (int k = 0; k < 12; k++) begin
            check("div1_sclk", int'(sclk1), k % 2);
            if (k % 2 == 1) check("div1_sdin", int'(sdin1), int'(bits1[(k - 1) / 2]));
            check("div1_done_ignored", int'(done1), 0);
            check("div1_busy", int'(busy1), 1);
            tick();
        end
        check("div1_wait_sclk", int'(sclk1), 0);
        check("div1_wait_done", int'(done1), 0);
        tick();
        check("div1_done", int'(done1), 1);
        check("div1_busy_done", int'(busy1), 0);
        check("div1_err", int'(err1), 0);
        tick();
        check("div1_done_pulse", int'(done1), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
